// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader
//   Packs instruction fields into 32-bit CPU instruction words and streams them into
//   instruction memory through a single write port, stalling on memory busywait.
//
// Ports
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_start                 begin a load session (pulse, honoured in IDLE/DONE only)
//   i_in_valid, o_in_ready  field-bundle handshake
//   i_fmt, i_opcode, i_writereg, i_readreg1, i_readreg2, i_immediate, i_offset, i_last
//                           instruction fields; i_fmt 0=RRR 1=RI 2=BR 3=J
//   o_mem_write, o_mem_addr, o_mem_writedata, i_mem_busywait
//                           instruction-memory write port
//   o_word_count            words committed this session
//   o_load_done             session finished
//   o_overflow              MAX_WORDS reached without LAST
module instruction_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 256,
    localparam int unsigned CW        = $clog2(MAX_WORDS) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [1:0]            i_fmt,
    input  logic [7:0]            i_opcode,
    input  logic [2:0]            i_writereg,
    input  logic [2:0]            i_readreg1,
    input  logic [2:0]            i_readreg2,
    input  logic [7:0]            i_immediate,
    input  logic [7:0]            i_offset,
    input  logic                  i_last,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_writedata,
    input  logic                  i_mem_busywait,
    output logic [CW-1:0]         o_word_count,
    output logic                  o_load_done,
    output logic                  o_overflow
);

    localparam logic [1:0]            FMT_RRR  = 2'd0;
    localparam logic [1:0]            FMT_RI   = 2'd1;
    localparam logic [1:0]            FMT_BR   = 2'd2;
    localparam logic [CW-1:0]         MAX_CNT  = CW'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_writedata;
    logic [CW-1:0]         r_word_count;
    logic                  r_load_done;
    logic                  r_overflow;
    logic                  r_last;

    logic [31:0]           w_encoded;
    logic [CW-1:0]         w_count_inc;
    logic                  w_full;

    // Field packing; every bit not named by the format stays 0.
    always_comb begin
        w_encoded        = 32'd0;
        w_encoded[31:24] = i_opcode;
        case (i_fmt)
            FMT_RRR: begin
                w_encoded[18:16] = i_writereg;
                w_encoded[10:8]  = i_readreg1;
                w_encoded[2:0]   = i_readreg2;
            end
            FMT_RI: begin
                w_encoded[18:16] = i_writereg;
                w_encoded[7:0]   = i_immediate;
            end
            FMT_BR: begin
                w_encoded[23:16] = i_offset;
                w_encoded[10:8]  = i_readreg1;
                w_encoded[2:0]   = i_readreg2;
            end
            default: begin
                w_encoded[23:16] = i_offset;
            end
        endcase
    end

    assign w_count_inc = r_word_count + CW'(1);
    assign w_full      = (w_count_inc == MAX_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_in_ready      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_addr      <= BASE;
            r_mem_writedata <= 32'd0;
            r_word_count    <= '0;
            r_load_done     <= 1'b0;
            r_overflow      <= 1'b0;
            r_last          <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state      <= ST_ACCEPT;
                        r_in_ready   <= 1'b1;
                        r_mem_addr   <= BASE;
                        r_word_count <= '0;
                        r_load_done  <= 1'b0;
                        r_overflow   <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    // r_in_ready is always 1 here, so i_in_valid alone completes the handshake.
                    if (i_in_valid) begin
                        r_mem_writedata <= w_encoded;
                        r_last          <= i_last;
                        r_mem_write     <= 1'b1;
                        r_in_ready      <= 1'b0;
                        r_state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!i_mem_busywait) begin
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= r_mem_addr + ADDR_INC;
                        r_word_count <= w_count_inc;
                        if (r_last || w_full) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                            r_overflow  <= w_full && !r_last;
                        end else begin
                            r_state    <= ST_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready      = r_in_ready;
    assign o_mem_write     = r_mem_write;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_writedata = r_mem_writedata;
    assign o_word_count    = r_word_count;
    assign o_load_done     = r_load_done;
    assign o_overflow      = r_overflow;

endmodule
